// File: rtl/dff_stream_deser_pkg.sv
// Shared types and helpers for the serial-bit deserializer that sits behind the DFF stage.
package dff_stream_deser_pkg;

   typedef enum logic [1:0] {HUNT, SHIFT, PARITY} deser_state_t;

   localparam logic START_BIT = 1'b1;
   localparam int unsigned PAR_MAX_W = 64;

   // Even parity holds when the data bits and the parity bit XOR to zero.
   function automatic logic even_parity_ok(input logic [PAR_MAX_W-1:0] data, input logic pbit);
      return ((^data) ^ pbit) == 1'b0;
   endfunction

endpackage

// File: rtl/dff_stream_hold.sv
// Single-entry valid/ready holding register for assembled words.
module dff_stream_hold
   import dff_stream_deser_pkg::*;
#(
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk,
   input  logic              clear_in,
   input  logic              load,
   input  logic [DATA_W-1:0] load_data,
   input  logic              word_ready,
   output logic [DATA_W-1:0] word_out,
   output logic              word_valid,
   output logic              can_load
);

   logic [DATA_W-1:0] word_q;
   logic              valid_q;

   assign word_out   = word_q;
   assign word_valid = valid_q;
   assign can_load   = !valid_q || word_ready;

   // A load on the drain edge keeps valid high with the new word.
   always_ff @(posedge clk) begin
      if (clear_in) begin
         word_q  <= '0;
         valid_q <= 1'b0;
      end else if (load) begin
         word_q  <= load_data;
         valid_q <= 1'b1;
      end else if (word_ready) begin
         valid_q <= 1'b0;
      end
   end

endmodule

// File: rtl/dff_stream_deser.sv
// Frames the qualified DFF bit stream (start, data MSB-first, optional even parity)
// and hands completed words to a valid/ready holding register.
module dff_stream_deser
   import dff_stream_deser_pkg::*;
#(
   parameter int unsigned DATA_W    = 8,
   parameter bit          PARITY_EN = 1'b1
) (
   input  logic              clk,
   input  logic              clear_in,
   input  logic              sin,
   input  logic              sin_en,
   input  logic              word_ready,
   input  logic              err_clr,
   output logic [DATA_W-1:0] word_out,
   output logic              word_valid,
   output logic              parity_err,
   output logic              overrun,
   output logic              busy
);

   localparam int unsigned CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

   deser_state_t      state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [DATA_W-1:0] shreg_q;
   logic              busy_q;
   logic              parity_err_q, parity_err_d;
   logic              overrun_q, overrun_d;

   logic [DATA_W-1:0] shreg_d;
   logic [DATA_W-1:0] load_data;
   logic              data_done, par_bit, par_ok;
   logic              word_done, word_bad, load, can_load;

   always_comb begin
      shreg_d   = {shreg_q[DATA_W-2:0], sin};
      data_done = sin_en && (state_q == SHIFT) && (cnt_q == LAST_CNT);
      par_bit   = PARITY_EN && sin_en && (state_q == PARITY);
      par_ok    = even_parity_ok(PAR_MAX_W'(shreg_q), sin);
      // With parity the word is complete in shreg_q; without it, the last bit is still in flight.
      word_done = PARITY_EN ? (par_bit && par_ok) : data_done;
      load_data = PARITY_EN ? shreg_q : shreg_d;
      word_bad  = par_bit && !par_ok;
      load      = word_done && can_load;
      parity_err_d = word_bad || (parity_err_q && !err_clr);
      overrun_d    = (word_done && !can_load) || (overrun_q && !err_clr);
   end

   always_ff @(posedge clk) begin
      if (clear_in) begin
         state_q      <= HUNT;
         cnt_q        <= '0;
         shreg_q      <= '0;
         busy_q       <= 1'b0;
         parity_err_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         parity_err_q <= parity_err_d;
         overrun_q    <= overrun_d;
         if (sin_en) begin
            case (state_q)
               HUNT: begin
                  if (sin == START_BIT) begin
                     state_q <= SHIFT;
                     cnt_q   <= '0;
                     busy_q  <= 1'b1;
                  end
               end
               SHIFT: begin
                  shreg_q <= shreg_d;
                  if (cnt_q == LAST_CNT) begin
                     cnt_q <= '0;
                     if (PARITY_EN) begin
                        state_q <= PARITY;
                     end else begin
                        state_q <= HUNT;
                        busy_q  <= 1'b0;
                     end
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
               PARITY: begin
                  state_q <= HUNT;
                  busy_q  <= 1'b0;
               end
               default: begin
                  state_q <= HUNT;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign parity_err = parity_err_q;
   assign overrun    = overrun_q;
   assign busy       = busy_q;

   dff_stream_hold #(.DATA_W(DATA_W)) u_hold (
      .clk        (clk),
      .clear_in   (clear_in),
      .load       (load),
      .load_data  (load_data),
      .word_ready (word_ready),
      .word_out   (word_out),
      .word_valid (word_valid),
      .can_load   (can_load)
   );

endmodule

// File: tb/tb_dff_stream_deser.sv
// Scoreboard bench: expected words are queued at stimulus time, the monitor pops on each transfer.
module tb_dff_stream_deser;

   logic       clk = 1'b0;
   logic       clear_in = 1'b1;
   logic       sin = 1'b0;
   logic       sin_en = 1'b0;
   logic       word_ready = 1'b1;
   logic       err_clr = 1'b0;
   logic [7:0] word_out;
   logic       word_valid, parity_err, overrun, busy;

   int unsigned tests = 0;
   int unsigned fails = 0;
   logic [7:0]  exp_q[$];

   always #5 clk = ~clk;

   dff_stream_deser #(.DATA_W(8), .PARITY_EN(1'b1)) dut (
      .clk        (clk),
      .clear_in   (clear_in),
      .sin        (sin),
      .sin_en     (sin_en),
      .word_ready (word_ready),
      .err_clr    (err_clr),
      .word_out   (word_out),
      .word_valid (word_valid),
      .parity_err (parity_err),
      .overrun    (overrun),
      .busy       (busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      sin = b;
      sin_en = 1'b1;
      tick();
      sin_en = 1'b0;
   endtask

   task automatic send_gap(input logic b);
      sin = b;
      sin_en = 1'b0;
      tick();
   endtask

   task automatic send_frame(input logic [7:0] d, input logic p, input bit clr_last, input bit rdy_last);
      send_bit(1'b1);
      for (int i = 7; i >= 0; i--) send_bit(d[i]);
      if (clr_last) err_clr = 1'b1;
      if (rdy_last) word_ready = 1'b1;
      send_bit(p);
      err_clr = 1'b0;
   endtask

   // Monitor: a transfer is valid & ready at the upcoming posedge; sampled mid-cycle.
   initial begin
      forever begin
         @(negedge clk);
         if (!clear_in && word_valid && word_ready) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_word: got %0h expected none", word_out);
            end else begin
               check("scoreboard_word", {24'd0, word_out}, {24'd0, exp_q.pop_front()});
            end
         end
      end
   end

   initial begin
      tick();
      tick();
      check("rst_word_out", {24'd0, word_out}, 32'h0);
      check("rst_valid", {31'd0, word_valid}, 32'd0);
      check("rst_perr", {31'd0, parity_err}, 32'd0);
      check("rst_overrun", {31'd0, overrun}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      clear_in = 1'b0;
      tick();

      // Basic frame
      exp_q.push_back(8'hA5);
      send_bit(1'b1);
      check("busy_after_start", {31'd0, busy}, 32'd1);
      for (int i = 7; i >= 0; i--) send_bit(logic'((8'hA5 >> i) & 8'h1));
      send_bit(1'b0);
      check("basic_valid", {31'd0, word_valid}, 32'd1);
      check("basic_word", {24'd0, word_out}, 32'hA5);
      check("basic_busy_done", {31'd0, busy}, 32'd0);
      tick();
      check("basic_valid_one_cycle", {31'd0, word_valid}, 32'd0);
      check("basic_no_perr", {31'd0, parity_err}, 32'd0);

      // Bad parity
      send_frame(8'hA5, 1'b1, 0, 0);
      check("badpar_valid", {31'd0, word_valid}, 32'd0);
      check("badpar_perr", {31'd0, parity_err}, 32'd1);
      tick();
      check("badpar_sticky", {31'd0, parity_err}, 32'd1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check("badpar_cleared", {31'd0, parity_err}, 32'd0);

      // Overrun, with err_clr on the overrun edge (set wins)
      word_ready = 1'b0;
      exp_q.push_back(8'hA5);
      send_frame(8'hA5, 1'b0, 0, 0);
      check("ovr_first_valid", {31'd0, word_valid}, 32'd1);
      send_frame(8'h3C, 1'b0, 1, 0);
      check("ovr_word_kept", {24'd0, word_out}, 32'hA5);
      check("ovr_flag_set_wins", {31'd0, overrun}, 32'd1);
      tick();
      check("ovr_stable", {24'd0, word_out}, 32'hA5);
      word_ready = 1'b1;
      tick();
      check("ovr_drained", {31'd0, word_valid}, 32'd0);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check("ovr_cleared", {31'd0, overrun}, 32'd0);

      // Gapped input with inverted sin on idle cycles
      exp_q.push_back(8'hFF);
      send_bit(1'b1);
      send_gap(1'b0);
      for (int i = 0; i < 8; i++) begin
         send_bit(1'b1);
         send_gap(1'b0);
      end
      send_bit(1'b0);
      check("gap_valid", {31'd0, word_valid}, 32'd1);
      check("gap_word", {24'd0, word_out}, 32'hFF);
      check("gap_perr", {31'd0, parity_err}, 32'd0);
      check("gap_overrun", {31'd0, overrun}, 32'd0);
      send_gap(1'b1);

      // Reset mid-frame
      send_bit(1'b1);
      send_bit(1'b1);
      send_bit(1'b1);
      send_bit(1'b1);
      send_bit(1'b1);
      check("mid_busy", {31'd0, busy}, 32'd1);
      clear_in = 1'b1;
      tick();
      clear_in = 1'b0;
      check("mid_rst_busy", {31'd0, busy}, 32'd0);
      exp_q.push_back(8'h01);
      send_frame(8'h01, 1'b1, 0, 0);
      check("mid_word", {24'd0, word_out}, 32'h01);
      check("mid_perr", {31'd0, parity_err}, 32'd0);
      tick();

      // Hunt noise, then back-to-back with load on the drain edge
      send_bit(1'b0);
      send_bit(1'b0);
      send_bit(1'b0);
      check("hunt_busy", {31'd0, busy}, 32'd0);
      word_ready = 1'b0;
      exp_q.push_back(8'h81);
      exp_q.push_back(8'h7E);
      send_frame(8'h81, 1'b0, 0, 0);
      check("b2b_first_word", {24'd0, word_out}, 32'h81);
      send_frame(8'h7E, 1'b0, 0, 1);
      check("b2b_valid_held", {31'd0, word_valid}, 32'd1);
      check("b2b_second_word", {24'd0, word_out}, 32'h7E);
      check("b2b_overrun", {31'd0, overrun}, 32'd0);
      tick();
      check("b2b_drained", {31'd0, word_valid}, 32'd0);
      tick();
      tick();
      check("scoreboard_empty", exp_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
